tube_scan_driver: RTL and testbench
===================================

Name: tube_scan_driver

Overview:
Output-side counterpart to the button/switch input conditioning: drives the 8-digit seven-segment display (tube_en, tube_l, tube_r) from a logical display image supplied by core. Time-multiplexes eight digits with inter-digit blanking to suppress ghosting, decodes 5-bit character codes, and supports per-digit blank, blink and decimal point. New images are taken through a shadow register and committed only at frame boundaries, so the display never tears.

Parameters:
DIGIT_CYCLES, 40000, clk cycles per digit slot (1 ms at 40 MHz pixel clock); legal range DIGIT_CYCLES > BLANK_CYCLES
BLANK_CYCLES, 400, cycles at start of each slot with all digits dark; must be >= 1
BLINK_FRAMES, 64, full frames per blink phase toggle; must be >= 1

Ports:
clk  in  1  pixel clock, same domain as core
reset  in  1  asynchronous, active-low reset
load  in  1  single-cycle strobe; captures digits/dp/blank_mask/blink_mask into shadow
digits  in  40  char code of digit i at [5i+4:5i]; i=7 leftmost
dp  in  8  decimal point on for digit i
blank_mask  in  8  digit i forced dark
blink_mask  in  8  digit i dark while blink_phase=1
pending  out  1  shadow holds data not yet committed
frame_tick  out  1  one-cycle pulse at end of each full 8-digit scan
tube_en  out  8  active-high digit enables, one-hot or zero
tube_l  out  8  segments for digits 7..4, active-high
tube_r  out  8  segments for digits 3..0, active-high

Behaviour:
- Segment bit order: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
- Char codes: 0-15 are hex 0-F (0=0xFC, 1=0x60, 8=0xFE, A=0xEE, F=0x8E). 16=blank 0x00, 17='-' 0x02, 18='H' 0x6E, 19='L' 0x1C, 20='P' 0xCE, 21='U' 0x7C. 22-31=blank. dp ORs bit0.
- Reset (async assert, any state): tube_en=0, tube_l=0, tube_r=0, pending=0, frame_tick=0.
  - Index=0, state=BLANK, slot counter=0, blink counter=0, blink_phase=0.
  - Committed image: all codes 16, dp=0, blank_mask=0xFF, blink_mask=0. Shadow: same.
- FSM per slot: BLANK for BLANK_CYCLES cycles, then SHOW for DIGIT_CYCLES-BLANK_CYCLES cycles. Then BLANK with index+1, mod 8 (7 wraps to 0).
- BLANK: all three tube outputs 0.
- SHOW, index i:
  - tube_en = 1<<i, unless blank_mask[i] or (blink_mask[i] & blink_phase); then tube_en=0.
  - If i>=4: tube_l = seg(i), tube_r = 0. Else: tube_r = seg(i), tube_l = 0.
- Outputs are registered and reflect the state/index of the same cycle. Frame period = 8*DIGIT_CYCLES.
- Frame end is the last SHOW cycle of index 7. On that cycle:
  - frame_tick=1 for exactly that cycle.
  - Commit: if pending or load, committed image <= shadow. Pending clears.
  - Blink counter increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Committed image first appears in index-0 SHOW of the next frame.
- load: shadow <= inputs on the cycle load=1, and pending <= 1.
  - Repeated loads before commit: last one wins.
  - load on the frame-end cycle: the incoming data is committed directly and pending=0 afterwards.
- Inputs are sampled only on load. Changes without load have no effect.

Test Plan:
- Use DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset release with no load -> tube_en=0 and tube_l/tube_r=0 for all 64 cycles; frame_tick pulses at cycles 63, 127.
- Load digits all=8, dp=0, blank_mask=0, blink_mask=0 mid-frame:
  - pending=1 until frame end, then 0.
  - Next frame: per slot, 2 cycles tube_en=0, then 6 cycles tube_en=0x01,0x02,...,0x80.
  - tube_r=0xFE for slots 0-3, tube_l=0xFE for slots 4-7, the inactive bus 0.
- digits=0x..., digit3=code 1 with dp[3]=1, digit5=17 -> slot 3 tube_r=0x61; slot 5 tube_l=0x02; code 25 -> 0x00.
- blank_mask=0x0F -> tube_en stays 0 in slots 0-3. blink_mask=0x80 -> digit 7 visible 2 frames, dark 2 frames, repeating.
- Two loads (A then B) before frame end -> only B displayed. Load exactly on the frame_tick cycle -> that data shows next frame, and pending=0 the following cycle.
- Assert reset during SHOW of index 5 -> outputs 0 immediately (async). After release, scanning restarts at index 0 with the blank image; pending=0.

Source files
------------

// File: rtl/tube_scan_driver.sv
// tube_scan_driver: 8-digit multiplexed seven-segment driver with frame-synchronous image commit
module tube_scan_driver #(
    parameter int DIGIT_CYCLES = 40000,
    parameter int BLANK_CYCLES = 400,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] digits,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    output logic        pending,
    output logic        frame_tick,
    output logic [7:0]  tube_en,
    output logic [7:0]  tube_l,
    output logic [7:0]  tube_r
);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    // Image layout: {digits[39:0], dp[7:0], blank_mask[7:0], blink_mask[7:0]}
    localparam logic [63:0] IMG_RST = {{8{5'd16}}, 8'h00, 8'hFF, 8'h00};

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [2:0]    r_idx, w_idx_nx;
    logic [BW-1:0] r_bcnt, w_bcnt_nx;
    logic          r_phase, w_phase_nx;
    logic [63:0]   r_sh, r_cm, w_cm_nx, w_in;
    logic          r_pending, w_pending_nx;
    logic          w_frame_end, w_tick_nx;
    logic [23:0]   w_out_nx;
    logic [7:0]    r_en, r_l, r_r;
    logic          r_tick;

    function automatic logic [7:0] seg_of(input logic [4:0] code);
        case (code)
            5'd0:    return 8'hFC;
            5'd1:    return 8'h60;
            5'd2:    return 8'hDA;
            5'd3:    return 8'hF2;
            5'd4:    return 8'h66;
            5'd5:    return 8'hB6;
            5'd6:    return 8'hBE;
            5'd7:    return 8'hE0;
            5'd8:    return 8'hFE;
            5'd9:    return 8'hF6;
            5'd10:   return 8'hEE;
            5'd11:   return 8'h3E;
            5'd12:   return 8'h9C;
            5'd13:   return 8'h7A;
            5'd14:   return 8'h9E;
            5'd15:   return 8'h8E;
            5'd17:   return 8'h02;
            5'd18:   return 8'h6E;
            5'd19:   return 8'h1C;
            5'd20:   return 8'hCE;
            5'd21:   return 8'h7C;
            default: return 8'h00;
        endcase
    endfunction

    // Returns {tube_en, tube_l, tube_r} for a given scan position and image
    function automatic logic [23:0] drive_of(input state_t s, input logic [2:0] i,
                                             input logic [63:0] img, input logic ph);
        logic [7:0] seg;
        logic       dark;
        logic       show;
        seg  = seg_of(img[24 + 5*int'(i) +: 5]) | {7'd0, img[16 + int'(i)]};
        dark = img[8 + int'(i)] | (img[int'(i)] & ph);
        show = (s == S_SHOW);
        return {(show && !dark) ? (8'b1 << i) : 8'h00,
                (show && i[2])  ? seg : 8'h00,
                (show && !i[2]) ? seg : 8'h00};
    endfunction

    // Next-state: slot timing, digit index, commit, blink, and the output values for next cycle
    always_comb begin
        w_in         = {digits, dp, blank_mask, blink_mask};
        w_frame_end  = (r_state == S_SHOW) && (r_idx == 3'd7) && (r_cnt == CW'(DIGIT_CYCLES - 1));
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 1'b1;
        w_idx_nx     = r_idx;
        if (r_state == S_BLANK && r_cnt == CW'(BLANK_CYCLES - 1))
            w_state_nx = S_SHOW;
        if (r_state == S_SHOW && r_cnt == CW'(DIGIT_CYCLES - 1)) begin
            w_state_nx = S_BLANK;
            w_cnt_nx   = '0;
            w_idx_nx   = r_idx + 3'd1;
        end
        w_cm_nx      = (w_frame_end && (r_pending || load)) ? (load ? w_in : r_sh) : r_cm;
        w_pending_nx = ~w_frame_end & (load | r_pending);
        w_bcnt_nx    = r_bcnt;
        w_phase_nx   = r_phase;
        if (w_frame_end) begin
            w_bcnt_nx  = (r_bcnt == BW'(BLINK_FRAMES - 1)) ? '0 : r_bcnt + 1'b1;
            w_phase_nx = (r_bcnt == BW'(BLINK_FRAMES - 1)) ? ~r_phase : r_phase;
        end
        w_tick_nx    = (w_state_nx == S_SHOW) && (w_idx_nx == 3'd7) && (w_cnt_nx == CW'(DIGIT_CYCLES - 1));
        w_out_nx     = drive_of(w_state_nx, w_idx_nx, w_cm_nx, w_phase_nx);
    end

    // State, image and registered outputs; outputs are computed from next-state so they match the cycle's state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_BLANK;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_bcnt    <= '0;
            r_phase   <= 1'b0;
            r_sh      <= IMG_RST;
            r_cm      <= IMG_RST;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_en      <= '0;
            r_l       <= '0;
            r_r       <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_bcnt    <= w_bcnt_nx;
            r_phase   <= w_phase_nx;
            r_sh      <= load ? w_in : r_sh;
            r_cm      <= w_cm_nx;
            r_pending <= w_pending_nx;
            r_tick    <= w_tick_nx;
            {r_en, r_l, r_r} <= w_out_nx;
        end
    end

    assign pending    = r_pending;
    assign frame_tick = r_tick;
    assign tube_en    = r_en;
    assign tube_l     = r_l;
    assign tube_r     = r_r;
endmodule

// File: tb/tb_tube_scan_driver.sv
// tb_tube_scan_driver: scoreboard bench for tube_scan_driver with short slot timing
module tb_tube_scan_driver;
    localparam int DC = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 8 * DC;
    localparam logic [7:0] SEG_T [0:21] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E,
                                           8'h00, 8'h02, 8'h6E, 8'h1C, 8'hCE, 8'h7C};

    typedef struct packed {logic [39:0] d; logic [7:0] dp; logic [7:0] bm; logic [7:0] km;} img_t;
    typedef struct packed {logic [7:0] en; logic [7:0] l; logic [7:0] r; logic tick; logic pend;} exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [39:0] digits = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  blank_mask = '0;
    logic [7:0]  blink_mask = '0;
    logic        pending;
    logic        frame_tick;
    logic [7:0]  tube_en;
    logic [7:0]  tube_l;
    logic [7:0]  tube_r;

    int   cyc;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   ld_cyc[2];
    img_t ld_img[2];
    int   n_ld = 0;
    img_t blank_img, all8, dec_img, bb_img, a_img, b_img, c_img;

    tube_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .load(load), .digits(digits), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .pending(pending),
        .frame_tick(frame_tick), .tube_en(tube_en), .tube_l(tube_l), .tube_r(tube_r)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input logic [4:0] c);
        return (c < 5'd22) ? SEG_T[c] : 8'h00;
    endfunction

    function automatic img_t mk(input logic [4:0] code, input logic [7:0] p, input logic [7:0] b, input logic [7:0] k);
        img_t m;
        m.d  = {8{code}};
        m.dp = p;
        m.bm = b;
        m.km = k;
        return m;
    endfunction

    function automatic exp_t model(input img_t im, input int c, input logic pend);
        exp_t e;
        int f, p, i, s;
        logic ph;
        logic [7:0] sg;
        f  = c / FR;
        p  = c % FR;
        i  = p / DC;
        s  = p % DC;
        ph = ((f / BF) % 2) == 1;
        e  = '0;
        e.pend = pend;
        e.tick = (p == FR - 1);
        if (s >= BC) begin
            sg = seg_of(im.d[i*5 +: 5]) | {7'd0, im.dp[i]};
            if (!(im.bm[i] || (im.km[i] && ph))) e.en = 8'd1 << i;
            if (i >= 4) e.l = sg;
            else e.r = sg;
        end
        return e;
    endfunction

    task automatic push_window(input int a, input int b, input img_t base);
        for (int c = a; c <= b; c++) begin
            img_t im;
            logic pend;
            im = base;
            pend = 1'b0;
            for (int k = 0; k < n_ld; k++) begin
                if ((ld_cyc[k] / FR) * FR + FR - 1 < c) im = ld_img[k];
                if (ld_cyc[k] < c && c <= (ld_cyc[k] / FR) * FR + FR - 1) pend = 1'b1;
            end
            sb.push_back(model(im, c, pend));
        end
    endtask

    task automatic at_cycle(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_assert++;
            n_fail++;
            $display("FAIL at_cycle: cycle %0d never reached (now %0d)", n, cyc);
        end
    endtask

    task automatic drive_loads(input int c);
        load       = 1'b0;
        digits     = {8'($urandom), $urandom};
        dp         = 8'($urandom);
        blank_mask = 8'($urandom);
        blink_mask = 8'($urandom);
        for (int k = 0; k < n_ld; k++)
            if (c == ld_cyc[k]) begin
                load = 1'b1;
                {digits, dp, blank_mask, blink_mask} = ld_img[k];
            end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_assert++;
        if ({tube_en, tube_l, tube_r, frame_tick, pending} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: en/l/r/tick/pend got %h/%h/%h/%b/%b exp 0", tube_en, tube_l, tube_r, frame_tick, pending);
        end
        reset = 1'b1;
        n_ld = 0;
        push_window(0, 2*FR - 1, blank_img);
        for (int c = 0; c <= 2*FR - 1; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL reset_scan cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_load_basic();
        n_ld = 1; ld_cyc[0] = 130; ld_img[0] = all8;
        push_window(128, 255, blank_img);
        for (int c = 128; c <= 255; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL load_basic cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_decode();
        n_ld = 1; ld_cyc[0] = 260; ld_img[0] = dec_img;
        push_window(256, 383, all8);
        for (int c = 256; c <= 383; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL decode cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_blank_blink();
        n_ld = 1; ld_cyc[0] = 390; ld_img[0] = bb_img;
        push_window(384, 703, dec_img);
        for (int c = 384; c <= 703; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL blank_blink cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        n_ld = 2; ld_cyc[0] = 710; ld_img[0] = a_img; ld_cyc[1] = 720; ld_img[1] = b_img;
        push_window(704, 831, bb_img);
        for (int c = 704; c <= 831; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_frame_end_load();
        n_ld = 1; ld_cyc[0] = 895; ld_img[0] = c_img;
        push_window(832, 959, b_img);
        for (int c = 832; c <= 959; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL frame_end_load cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        n_ld = 1; ld_cyc[0] = 1000; ld_img[0] = all8;
        push_window(960, 1003, c_img);
        for (int c = 960; c <= 1003; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_assert++;
        if ({tube_en, tube_l, tube_r, frame_tick, pending} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h/%h/%b/%b exp 0", tube_en, tube_l, tube_r, frame_tick, pending);
        end
        @(negedge clk);
        reset = 1'b1;
        n_ld = 0;
        push_window(0, FR - 1, blank_img);
        for (int c = 0; c <= FR - 1; c++) begin
            exp_t e;
            at_cycle(c);
            e = sb.pop_front();
            n_assert++;
            if ({tube_en, tube_l, tube_r, frame_tick, pending} !== e) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", c,
                         tube_en, tube_l, tube_r, frame_tick, pending, e.en, e.l, e.r, e.tick, e.pend);
            end
            drive_loads(c);
        end
        load = 1'b0;
    endtask

    initial begin
        blank_img = mk(5'd16, 8'h00, 8'hFF, 8'h00);
        all8      = mk(5'd8,  8'h00, 8'h00, 8'h00);
        dec_img   = '{d: {5'd19, 5'd18, 5'd17, 5'd20, 5'd1, 5'd15, 5'd10, 5'd25}, dp: 8'h08, bm: 8'h00, km: 8'h00};
        bb_img    = mk(5'd8,  8'h00, 8'h0F, 8'h80);
        a_img     = mk(5'd2,  8'h00, 8'h00, 8'h00);
        b_img     = mk(5'd3,  8'hAA, 8'h00, 8'h00);
        c_img     = mk(5'd5,  8'hFF, 8'h00, 8'h00);
        test_reset();
        test_load_basic();
        test_decode();
        test_blank_blink();
        test_back_to_back();
        test_frame_end_load();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
